// File: rtl/ads8528_responder_if.sv
// Parallel-bus bundle between the ADC controller (master) and the ADS8528 responder (slave).
interface ads8528_responder_if #(
  parameter int DATA_WIDTH = 16
);
  logic                      read_n;
  logic                      write_n;
  logic                      chipselect_n;
  logic                      hardware_mode_n;
  logic                      parallel_mode_n;
  logic                      standby_n;
  logic                      conv_start_a;
  logic                      conv_start_b;
  logic                      conv_start_c;
  logic                      conv_start_d;
  logic [DATA_WIDTH-1:0]     data_in;
  logic [8*DATA_WIDTH-1:0]   sample_in;
  logic                      busy;
  logic [DATA_WIDTH-1:0]     data_out;
  logic                      data_oe;
  logic [DATA_WIDTH-1:0]     config_out;
  logic                      overrun;

  modport master (
    output read_n, write_n, chipselect_n, hardware_mode_n, parallel_mode_n, standby_n,
    output conv_start_a, conv_start_b, conv_start_c, conv_start_d, data_in, sample_in,
    input  busy, data_out, data_oe, config_out, overrun
  );

  modport slave (
    input  read_n, write_n, chipselect_n, hardware_mode_n, parallel_mode_n, standby_n,
    input  conv_start_a, conv_start_b, conv_start_c, conv_start_d, data_in, sample_in,
    output busy, data_out, data_oe, config_out, overrun
  );
endinterface

// File: rtl/ads8528_responder.sv
// ADS8528 converter-side model: timed busy pulse, 8-channel read sequencing, config latch.
// Optional ADS8528_RESPONDER_RAMP_EN replaces sample_in with per-channel ramp counters.
module ads8528_responder #(
  parameter int DATA_WIDTH  = 16,
  parameter int CONV_CYCLES = 64,
  parameter int NUM_CH      = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  ads8528_responder_if.slave   bus
);
  localparam int CW = 10;
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_CONV = 1'b1;

  logic                  read_n_r;
  logic                  write_n_r;
  logic [3:0]            start_r;
  logic [3:0]            start_s;
  logic [3:0]            rise_s;
  logic                  read_fall_s;
  logic                  write_rise_s;
  logic                  powered_down_s;
  logic                  read_en_s;
  logic                  write_en_s;
  logic                  conv_done_s;

  logic [0:0]            state_r;
  logic [CW-1:0]         cnt_r;
  logic [3:0]            pend_r;
  logic                  busy_r;
  logic [2:0]            ptr_r;
  logic [DATA_WIDTH-1:0] hold_r   [NUM_CH];
  logic [DATA_WIDTH-1:0] result_r [NUM_CH];
  logic [DATA_WIDTH-1:0] sample_s [NUM_CH];
  logic [DATA_WIDTH-1:0] data_out_r;
  logic [DATA_WIDTH-1:0] config_r;
  logic                  overrun_r;

  // Strobe decode from the current inputs and their one-cycle history.
  always_comb begin
    start_s        = {bus.conv_start_d, bus.conv_start_c, bus.conv_start_b, bus.conv_start_a};
    rise_s         = start_s & ~start_r;
    read_fall_s    = !bus.read_n && read_n_r;
    write_rise_s   = bus.write_n && !write_n_r;
    powered_down_s = !bus.hardware_mode_n && !bus.standby_n;
    read_en_s      = !bus.chipselect_n && !bus.parallel_mode_n && read_fall_s;
    write_en_s     = !bus.chipselect_n && bus.hardware_mode_n && write_rise_s;
    conv_done_s    = (state_r == ST_CONV) && !powered_down_s && (cnt_r == {CW{1'b0}});
  end

`ifdef ADS8528_RESPONDER_RAMP_EN
  logic [DATA_WIDTH-4:0] ramp_r [NUM_CH];

  // Channel index in the top bits makes each captured word self-identifying.
  always_comb begin
    for (int k = 0; k < NUM_CH; k++) begin
      sample_s[k] = {3'(k), ramp_r[k]};
    end
  end

  // Ramp counters advance only for pairs whose conversion completed.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < NUM_CH; k++) ramp_r[k] <= '0;
    end else if (conv_done_s) begin
      for (int k = 0; k < NUM_CH; k++) begin
        if (pend_r[k>>1]) ramp_r[k] <= ramp_r[k] + 1'b1;
      end
    end
  end
`else
  // Channel k is a straight slice of the analog stand-in bus.
  always_comb begin
    for (int k = 0; k < NUM_CH; k++) begin
      sample_s[k] = bus.sample_in[k*DATA_WIDTH +: DATA_WIDTH];
    end
  end
`endif

  // Edge-detect history registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      read_n_r  <= 1'b1;
      write_n_r <= 1'b1;
      start_r   <= 4'b0000;
    end else begin
      read_n_r  <= bus.read_n;
      write_n_r <= bus.write_n;
      start_r   <= start_s;
    end
  end

  // Conversion FSM: capture on start, count down, publish results or abort on power-down.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= ST_IDLE;
      cnt_r   <= {CW{1'b0}};
      pend_r  <= 4'b0000;
      busy_r  <= 1'b0;
      for (int k = 0; k < NUM_CH; k++) begin
        hold_r[k]   <= '0;
        result_r[k] <= '0;
      end
    end else begin
      case (state_r)
        ST_IDLE: begin
          if ((|rise_s) && !powered_down_s) begin
            for (int k = 0; k < NUM_CH; k++) begin
              if (rise_s[k>>1]) hold_r[k] <= sample_s[k];
            end
            pend_r  <= rise_s;
            cnt_r   <= CW'(CONV_CYCLES - 1);
            busy_r  <= 1'b1;
            state_r <= ST_CONV;
          end
        end
        ST_CONV: begin
          if (powered_down_s) begin
            pend_r  <= 4'b0000;
            busy_r  <= 1'b0;
            state_r <= ST_IDLE;
          end else if (conv_done_s) begin
            for (int k = 0; k < NUM_CH; k++) begin
              if (pend_r[k>>1]) result_r[k] <= hold_r[k];
            end
            pend_r  <= 4'b0000;
            busy_r  <= 1'b0;
            state_r <= ST_IDLE;
          end else begin
            cnt_r <= cnt_r - 1'b1;
          end
        end
        default: begin
          pend_r  <= 4'b0000;
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  // Read pointer: completion rewinds to A0, otherwise each accepted read advances it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr_r <= 3'd0;
    end else if (conv_done_s) begin
      ptr_r <= 3'd0;
    end else if (read_en_s) begin
      ptr_r <= ptr_r + 3'd1;
    end
  end

  // Read data, config latch and sticky overrun.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_out_r <= '0;
      config_r   <= '0;
      overrun_r  <= 1'b0;
    end else begin
      if (read_en_s) data_out_r <= result_r[ptr_r];
      if (write_en_s) config_r <= bus.data_in;
      if ((state_r == ST_CONV) && (|rise_s)) overrun_r <= 1'b1;
    end
  end

  assign bus.busy       = busy_r;
  assign bus.data_out   = data_out_r;
  assign bus.config_out = config_r;
  assign bus.overrun    = overrun_r;
  assign bus.data_oe    = !bus.chipselect_n && !bus.read_n && !bus.parallel_mode_n;

endmodule

// File: tb/tb_ads8528_responder.sv
// Directed bench for ads8528_responder: expected read words go through a scoreboard queue.
module tb_ads8528_responder;
  localparam int DW = 16;

  logic clk;
  logic reset_n;
  int   checks;
  int   failures;
  int   len;

  logic [DW-1:0] exp_res [8];
  logic [2:0]    exp_ptr;
  logic [DW-1:0] exp_last;
  logic [DW-1:0] sb [$];

  ads8528_responder_if #(.DATA_WIDTH(DW)) bus ();

  ads8528_responder #(.DATA_WIDTH(DW), .CONV_CYCLES(64), .NUM_CH(8)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_ch(input int k, input logic [DW-1:0] v);
    bus.sample_in[k*DW +: DW] = v;
  endtask

  task automatic set_starts(input logic [3:0] m);
    bus.conv_start_a = m[0];
    bus.conv_start_b = m[1];
    bus.conv_start_c = m[2];
    bus.conv_start_d = m[3];
  endtask

  // Starts a conversion and counts busy cycles; optional late start / power-down injection.
  task automatic run_conv(input logic [3:0] mask, input int inj_at, input logic [3:0] inj_mask,
                          input int pd_at, output int n);
    n = 0;
    @(negedge clk);
    set_starts(mask);
    @(negedge clk);
    set_starts(4'b0000);
    for (int i = 0; i < 200; i++) begin
      if (bus.busy !== 1'b1) break;
      n++;
      if (n == inj_at) set_starts(inj_mask);
      else set_starts(4'b0000);
      if (n == pd_at) begin
        bus.hardware_mode_n = 1'b0;
        bus.standby_n       = 1'b0;
      end
      @(negedge clk);
    end
    set_starts(4'b0000);
    bus.hardware_mode_n = 1'b1;
    bus.standby_n       = 1'b1;
  endtask

  task automatic do_read(input string tag);
    logic [DW-1:0] e;
    logic          exp_oe;
    @(negedge clk);
    bus.read_n = 1'b0;
    exp_oe = !bus.chipselect_n && !bus.parallel_mode_n;
    if (!bus.parallel_mode_n) begin
      sb.push_back(exp_res[exp_ptr]);
      exp_ptr = exp_ptr + 3'd1;
    end
    @(negedge clk);
    chk({tag, "_oe"}, {31'd0, bus.data_oe}, {31'd0, exp_oe});
    if (sb.size() > 0) begin
      e = sb.pop_front();
      exp_last = e;
    end else begin
      e = exp_last;
    end
    chk(tag, {16'd0, bus.data_out}, {16'd0, e});
    bus.read_n = 1'b1;
  endtask

  task automatic write_word(input logic hw, input logic [DW-1:0] d);
    @(negedge clk);
    bus.hardware_mode_n = hw;
    bus.data_in         = d;
    bus.write_n         = 1'b0;
    @(negedge clk);
    bus.write_n = 1'b1;
    @(negedge clk);
    bus.hardware_mode_n = 1'b1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    exp_ptr  = 3'd0;
    exp_last = 16'h0000;
    for (int k = 0; k < 8; k++) exp_res[k] = 16'h0000;
    reset_n              = 1'b0;
    bus.read_n           = 1'b1;
    bus.write_n          = 1'b1;
    bus.chipselect_n     = 1'b1;
    bus.hardware_mode_n  = 1'b1;
    bus.parallel_mode_n  = 1'b0;
    bus.standby_n        = 1'b1;
    bus.data_in          = 16'h0000;
    bus.sample_in        = '0;
    set_starts(4'b0000);

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_data_out", {16'd0, bus.data_out}, 32'd0);
    chk("rst_config", {16'd0, bus.config_out}, 32'd0);
    chk("rst_overrun", {31'd0, bus.overrun}, 32'd0);
    chk("rst_oe", {31'd0, bus.data_oe}, 32'd0);
    reset_n = 1'b1;
    @(negedge clk);
    bus.chipselect_n = 1'b0;

    // Single pair A conversion
    set_ch(0, 16'h1234);
    set_ch(1, 16'h5678);
    run_conv(4'b0001, -1, 4'b0000, -1, len);
    chk("t1_busy_len", len, 32'd64);
    exp_res[0] = 16'h1234;
    exp_res[1] = 16'h5678;
    exp_ptr = 3'd0;
    do_read("t1_rd0");
    do_read("t1_rd1");

    // All four pairs together, nine reads to show the wrap
    for (int k = 0; k < 8; k++) set_ch(k, 16'h1000 + DW'(k));
    run_conv(4'b1111, -1, 4'b0000, -1, len);
    chk("t2_busy_len", len, 32'd64);
    for (int k = 0; k < 8; k++) exp_res[k] = 16'h1000 + DW'(k);
    exp_ptr = 3'd0;
    for (int i = 0; i < 9; i++) do_read($sformatf("t2_rd%0d", i));

    // Late start on pair B during CONV -> overrun, B untouched
    set_ch(0, 16'h2222);
    set_ch(1, 16'h3333);
    set_ch(2, 16'hBEEF);
    set_ch(3, 16'hBEEF);
    run_conv(4'b0001, 10, 4'b0010, -1, len);
    chk("t3_busy_len", len, 32'd64);
    chk("t3_overrun", {31'd0, bus.overrun}, 32'd1);
    exp_res[0] = 16'h2222;
    exp_res[1] = 16'h3333;
    exp_ptr = 3'd0;
    for (int i = 0; i < 4; i++) do_read($sformatf("t3_rd%0d", i));

    // Power-down abort at CONV cycle 20
    set_ch(4, 16'hCCCC);
    set_ch(5, 16'hCCCC);
    run_conv(4'b0100, -1, 4'b0000, 20, len);
    chk("t4_busy_len", len, 32'd20);
    chk("t4_busy_low", {31'd0, bus.busy}, 32'd0);
    do_read("t4_rd4");
    do_read("t4_rd5");

    // Config writes: software mode latches, hardware mode ignored
    write_word(1'b1, 16'hA5C3);
    chk("t5_cfg_sw", {16'd0, bus.config_out}, 32'h0000A5C3);
    write_word(1'b0, 16'h0000);
    chk("t5_cfg_hw", {16'd0, bus.config_out}, 32'h0000A5C3);

    // Serial mode: bus disabled, pointer held
    bus.parallel_mode_n = 1'b1;
    do_read("t6_ser0");
    do_read("t6_ser1");
    bus.parallel_mode_n = 1'b0;
    do_read("t6_par6");

    // Reset in the middle of a read
    @(negedge clk);
    bus.read_n = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    chk("t6_rst_data_out", {16'd0, bus.data_out}, 32'd0);
    chk("t6_rst_config", {16'd0, bus.config_out}, 32'd0);
    chk("t6_rst_overrun", {31'd0, bus.overrun}, 32'd0);
    bus.read_n = 1'b1;
    for (int k = 0; k < 8; k++) exp_res[k] = 16'h0000;
    exp_ptr  = 3'd0;
    exp_last = 16'h0000;
    @(negedge clk);
    reset_n = 1'b1;
    set_ch(0, 16'h4321);
    set_ch(1, 16'h8765);
    run_conv(4'b0001, -1, 4'b0000, -1, len);
    chk("t7_busy_len", len, 32'd64);
    exp_res[0] = 16'h4321;
    exp_res[1] = 16'h8765;
    exp_ptr = 3'd0;
    do_read("t7_rd0");
    do_read("t7_rd1");
    do_read("t7_rd2");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
